// File: rtl/conv_pkg.sv
// conv_pkg: shared convolution constants and pad-FSM state encoding
package conv_pkg;
  localparam int IMG_HEIGHT  = 480;
  localparam int IMG_NB      = 7;
  localparam int IMG_WIDTH   = 640;
  localparam int KERNEL_SIZE = 3;
  localparam int KERNEL_NB   = 8;
  localparam int RESULT_NB   = 19;
  typedef enum logic [1:0] {
    S_PRE  = 2'd0,
    S_DATA = 2'd1,
    S_POST = 2'd2
  } pad_state_t;
endpackage

// File: rtl/conv_col_feeder_if.sv
// conv_col_feeder_if: pixel stream in, column stream out, with valid/ready on both sides
interface conv_col_feeder_if #(
  parameter int IMG_HEIGHT = conv_pkg::IMG_HEIGHT,
  parameter int IMG_NB     = conv_pkg::IMG_NB
);
  logic [IMG_NB-1:0]            i_pixel;
  logic                         i_valid;
  logic                         o_ready;
  logic [IMG_HEIGHT*IMG_NB-1:0] o_col;
  logic                         o_col_valid;
  logic                         i_col_ready;
  logic                         o_last_col;
  modport slave (
    input  i_pixel, i_valid, i_col_ready,
    output o_ready, o_col, o_col_valid, o_last_col
  );
  modport master (
    output i_pixel, i_valid, i_col_ready,
    input  o_ready, o_col, o_col_valid, o_last_col
  );
endinterface

// File: rtl/conv_col_bank.sv
// conv_col_bank: one column of pixels as a shift register, new pixel enters at the LSB
module conv_col_bank #(
  parameter int W  = 3360,
  parameter int NB = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [NB-1:0] i_d,
  output logic [W-1:0]  o_q
);
  logic [W-1:0] r_q;
  // Shift the column up by one pixel on each enabled beat
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= '0;
    else if (i_en) r_q <= {r_q[W-NB-1:0], i_d};
  assign o_q = r_q;
endmodule

// File: rtl/conv_col_feeder.sv
// conv_col_feeder: double-banked raster-to-column feeder; FEEDER_ZERO_PAD_EN adds zero border columns
module conv_col_feeder #(
  parameter int IMG_HEIGHT = conv_pkg::IMG_HEIGHT,
  parameter int IMG_NB     = conv_pkg::IMG_NB,
  parameter int IMG_WIDTH  = conv_pkg::IMG_WIDTH
) (
  input logic              clk100,
  input logic              in_reset,
  conv_col_feeder_if.slave bus
);
  import conv_pkg::*;
  localparam int WC = IMG_HEIGHT * IMG_NB;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  logic [1:0]    r_full;
  logic          r_wr;
  logic          r_rd;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [WC-1:0] w_bank [2];
  logic          w_acc;
  logic          w_take;
  logic          w_data;
  logic          w_row_end;
  logic          w_col_end;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;
  assign w_acc     = bus.i_valid & bus.o_ready;
  assign w_row_end = r_row == RW'(IMG_HEIGHT - 1);
  assign w_col_end = r_col == CW'(IMG_WIDTH - 1);
  assign w_take    = w_data & r_full[r_rd] & bus.i_col_ready;
  assign w_set     = {2{w_acc & w_row_end}} & (r_wr ? 2'b10 : 2'b01);
  assign w_clr     = {2{w_take}} & (r_rd ? 2'b10 : 2'b01);
  assign bus.o_ready = ~r_full[r_wr];
  genvar b;
  for (b = 0; b < 2; b++) begin : g_bank
    conv_col_bank #(.W(WC), .NB(IMG_NB)) u_bank (
      .clk  (clk100),
      .rst  (in_reset),
      .i_en (w_acc & (r_wr == 1'(b))),
      .i_d  (bus.i_pixel),
      .o_q  (w_bank[b])
    );
  end
  // Bank-full flags, bank pointers and row/column counters
  always_ff @(posedge clk100 or posedge in_reset)
    if (in_reset) begin
      r_full <= '0;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_row  <= '0;
      r_col  <= '0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_acc) r_row <= w_row_end ? '0 : r_row + 1'b1;
      if (w_acc & w_row_end) r_wr <= ~r_wr;
      if (w_take) r_rd <= ~r_rd;
      if (w_take) r_col <= w_col_end ? '0 : r_col + 1'b1;
    end
`ifdef FEEDER_ZERO_PAD_EN
  pad_state_t r_state;
  pad_state_t w_state_nxt;
  assign w_data = r_state == S_DATA;
  // Pad FSM state register
  always_ff @(posedge clk100 or posedge in_reset)
    if (in_reset) r_state <= S_PRE;
    else r_state <= w_state_nxt;
  // Pad FSM: zero column before and after each frame's data columns
  always_comb begin
    w_state_nxt     = r_state;
    bus.o_col_valid = w_data ? r_full[r_rd] : 1'b1;
    bus.o_col       = w_data ? w_bank[r_rd] : '0;
    bus.o_last_col  = r_state == S_POST;
    w_state_nxt     = (r_state == S_PRE  && bus.i_col_ready) ? S_DATA :
                      (r_state == S_POST && bus.i_col_ready) ? S_PRE  :
                      (w_take && w_col_end)                  ? S_POST : r_state;
  end
`else
  assign w_data = 1'b1;
  // Present the read bank; last-column flag only while a column is presented
  always_comb begin
    bus.o_col_valid = r_full[r_rd];
    bus.o_col       = w_bank[r_rd];
    bus.o_last_col  = r_full[r_rd] & w_col_end;
  end
`endif
endmodule

// File: tb/tb_conv_col_feeder.sv
// tb_conv_col_feeder: directed + random stimulus against a column-queue model of the feeder
module tb_conv_col_feeder;
  localparam int H  = 480;
  localparam int NB = 7;
  localparam int W  = 4;
  localparam int HN = H * NB;
`ifdef FEEDER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  logic clk100 = 1'b0;
  logic in_reset = 1'b1;
  int tests = 0;
  int fails = 0;
  conv_col_feeder_if #(.IMG_HEIGHT(H), .IMG_NB(NB)) bus ();
  conv_col_feeder #(.IMG_HEIGHT(H), .IMG_NB(NB), .IMG_WIDTH(W)) dut (
    .clk100   (clk100),
    .in_reset (in_reset),
    .bus      (bus)
  );
  always #5 clk100 = ~clk100;
  logic [HN-1:0] fq [$];
  logic [HN-1:0] cur;
  int n;
  int cidx;
  int ph;
  function automatic void mreset();
    fq.delete();
    cur  = '0;
    n    = 0;
    cidx = 0;
    ph   = PAD ? 0 : 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chkcol(input string tag, input logic [HN-1:0] got, input logic [HN-1:0] exp);
    int r;
    r = 0;
    tests++;
    assert (got === exp) else begin
      for (int i = H - 1; i >= 0; i--)
        if (got[HN-1-NB*i -: NB] !== exp[HN-1-NB*i -: NB]) r = i;
      fails++;
      $error("FAIL %s row %0d got=%h exp=%h", tag, r, got[HN-1-NB*r -: NB], exp[HN-1-NB*r -: NB]);
    end
  endtask
  task automatic step(output bit acc);
    bit er, ev, el, tk;
    logic [HN-1:0] ec;
    er = fq.size() < 2;
    ec = '0;
    if (ph != 1) begin
      ev = 1'b1;
      el = ph == 2;
    end else begin
      ev = fq.size() > 0;
      if (ev) ec = fq[0];
      el = ev && !PAD && cidx == W - 1;
    end
    chk("o_ready", bus.o_ready, er);
    chk("o_col_valid", bus.o_col_valid, ev);
    if (ev) begin
      chkcol("o_col", bus.o_col, ec);
      chk("o_last_col", bus.o_last_col, el);
    end
    acc = bus.i_valid && er;
    tk  = bus.i_col_ready && ev;
    if (tk) begin
      if (ph == 0) ph = 1;
      else if (ph == 2) ph = 0;
      else begin
        void'(fq.pop_front());
        if (PAD && cidx == W - 1) ph = 2;
        cidx = (cidx + 1) % W;
      end
    end
    if (acc) begin
      cur[HN-1-NB*n -: NB] = bus.i_pixel;
      n++;
      if (n == H) begin
        fq.push_back(cur);
        cur = '0;
        n   = 0;
      end
    end
    @(negedge clk100);
  endtask
  task automatic feed(input int cnt, input int kind, input logic [NB-1:0] v, input logic cr);
    bit a;
    int g;
    for (int k = 0; k < cnt; k++) begin
      bus.i_valid     = 1'b1;
      bus.i_pixel     = kind == 0 ? NB'(k % 128) : kind == 1 ? v : NB'($urandom);
      bus.i_col_ready = cr;
      g = 0;
      do begin
        step(a);
        g++;
      end while (!a && g < 2000);
      chk("accept_budget", g < 2000, 1);
    end
    bus.i_valid = 1'b0;
  endtask
  task automatic do_reset();
    in_reset        = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_col_ready = 1'b0;
    repeat (2) begin
      @(negedge clk100);
      chk("rst_valid", bus.o_col_valid, PAD);
      chkcol("rst_col", bus.o_col, '0);
      chk("rst_last", bus.o_last_col, 0);
    end
    in_reset = 1'b0;
    mreset();
    chk("rst_ready", bus.o_ready, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "timeout");
  end
  initial begin
    bit a;
    bus.i_valid     = 1'b0;
    bus.i_pixel     = '0;
    bus.i_col_ready = 1'b0;
    mreset();
    // 1: ramp column, one-cycle latency, row placement
    do_reset();
    feed(H, 0, '0, 1'b1);
    chk("t1_valid", bus.o_col_valid, 1);
    chk("t1_row0", bus.o_col[HN-1 -: NB], 0);
    chk("t1_row1", bus.o_col[HN-1-NB -: NB], 1);
    chk("t1_row479", bus.o_col[NB-1:0], 95);
    bus.i_col_ready = 1'b1;
    step(a);
    chk("t1_valid_fall", bus.o_col_valid, 0);
    // 2: both banks full, stall, ordered drain
    feed(H, 1, 7'h11, 1'b0);
    feed(H, 1, 7'h22, 1'b0);
    chk("t2_stall", bus.o_ready, 0);
    bus.i_valid = 1'b1;
    bus.i_pixel = 7'h7F;
    repeat (5) step(a);
    bus.i_valid = 1'b0;
    chk("t2_headA", bus.o_col[HN-1 -: NB], 7'h11);
    bus.i_col_ready = 1'b1;
    step(a);
    bus.i_col_ready = 1'b0;
    chk("t2_ready_back", bus.o_ready, 1);
    chk("t2_headB", bus.o_col[NB-1:0], 7'h22);
    step(a);
    bus.i_col_ready = 1'b1;
    step(a);
    step(a);
    // 3/4: continuous stream, wraps across two frames
    feed(8 * H, 2, '0, 1'b1);
    repeat (3) step(a);
    // 5: reset mid-column discards partial data
    feed(100, 1, 7'h7F, 1'b1);
    do_reset();
    feed(H, 1, 7'h01, 1'b0);
    chk("t5_row0", bus.o_col[HN-1 -: NB], PAD ? 0 : 1);
    chk("t5_valid", bus.o_col_valid, 1);
    bus.i_col_ready = 1'b1;
    repeat (4) step(a);
    // random traffic on both handshakes
    for (int c = 0; c < 8000; c++) begin
      bus.i_valid     = $urandom_range(0, 9) < 8;
      bus.i_pixel     = NB'($urandom);
      bus.i_col_ready = 1'($urandom_range(0, 1));
      step(a);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
